// File: rtl/rv_regfile_wb_if.sv
// ----------------------------------------------------------------------------
// rv_regfile_wb_if
// Command/ALU bus between an instruction source plus R-type ALU (master side)
// and the register-file/write-back controller (slave side).
//   InstrValid  : source has a command word on Instruction
//   Instruction : RV32 command word
//   InstrReady  : controller accepts the command on the edge where both are 1
//   Command     : command latched by the controller, fed to the ALU
//   RegFile     : full 32x32 register array, fed to the ALU operand mux
//   AluResult   : ALU result for Command
// ----------------------------------------------------------------------------
interface rv_regfile_wb_if;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic        InstrReady;
  logic [31:0] Command;
  logic [31:0] RegFile [32];
  logic [31:0] AluResult;

  modport slave (
    input  InstrValid, Instruction, AluResult,
    output InstrReady, Command, RegFile
  );

  modport master (
    output InstrValid, Instruction, AluResult,
    input  InstrReady, Command, RegFile
  );
endinterface

// File: rtl/rv_regfile_wb.sv
// ----------------------------------------------------------------------------
// rv_regfile_wb
// 32x32 register file with a three-state command sequencer (IDLE->EXEC->WB).
// A command is latched in IDLE, the external ALU result is captured in EXEC,
// and the result is committed to reg[rd] in WB when the command is a legal
// R-type. x0 is hard-wired to zero.
//
// Ports
//   Clk, Rst        : clock, synchronous active-high reset
//   bus (slave)     : InstrValid/Instruction/InstrReady handshake, Command and
//                     RegFile toward the ALU, AluResult back from it
//   HostWrEn/Addr/Data : host preload port, honoured only in IDLE
//   HostRdAddr/Data : combinational host read of the registered array
//   WbDone/WbRd/WbData : commit pulse with destination and value
//   Illegal         : pulse when the latched command is not a legal R-type
//   RetireCnt       : committed-instruction counter
//
// Build option
//   RV_REGFILE_WB_RETIRE_CNT_EN : when defined, RetireCnt counts WbDone pulses
//   (wrapping); when undefined, RetireCnt is tied to 0 and no counter exists.
// ----------------------------------------------------------------------------
module rv_regfile_wb (
  input  logic              Clk,
  input  logic              Rst,
  rv_regfile_wb_if.slave    bus,
  input  logic              HostWrEn,
  input  logic [4:0]        HostWrAddr,
  input  logic [31:0]       HostWrData,
  input  logic [4:0]        HostRdAddr,
  output logic [31:0]       HostRdData,
  output logic              WbDone,
  output logic [4:0]        WbRd,
  output logic [31:0]       WbData,
  output logic              Illegal,
  output logic [31:0]       RetireCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] result_q, result_d;
  logic        legal_q, legal_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  cmd_rd;

  function automatic logic is_legal_rtype(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7);
    is_legal_rtype = (opcode == 7'b0110011) &&
                     ((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) &&
                       ((funct3 == 3'b000) || (funct3 == 3'b101))));
  endfunction

  assign cmd_rd = cmd_q[11:7];

  always_comb begin
    state_d        = state_q;
    regs_d         = regs_q;
    cmd_d          = cmd_q;
    result_d       = result_q;
    legal_d        = legal_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    bus.InstrReady = 1'b0;
    WbDone         = 1'b0;
    Illegal        = 1'b0;
    case (state_q)
      IDLE: begin
        // A host write takes priority and blocks acceptance for that cycle.
        bus.InstrReady = !HostWrEn && !Rst;
        if (HostWrEn) begin
          if (HostWrAddr != 5'd0) regs_d[HostWrAddr] = HostWrData;
        end else if (bus.InstrValid) begin
          cmd_d   = bus.Instruction;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.AluResult;
        legal_d  = is_legal_rtype(cmd_q[6:0], cmd_q[14:12], cmd_q[31:25]);
        state_d  = WB;
      end
      WB: begin
        state_d = IDLE;
        // Pulses are masked by Rst so an aborted command leaves no trace.
        if (legal_q) begin
          WbDone    = !Rst;
          wb_rd_d   = cmd_rd;
          wb_data_d = result_q;
          if (cmd_rd != 5'd0) regs_d[cmd_rd] = result_q;
        end else begin
          Illegal = !Rst;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      result_q  <= '0;
      legal_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      result_q  <= result_d;
      legal_q   <= legal_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      regs_q    <= regs_d;
    end
  end

  // WbRd/WbData show the committing values during the WbDone cycle and the
  // last committed values otherwise.
  assign WbRd        = WbDone ? cmd_rd   : wb_rd_q;
  assign WbData      = WbDone ? result_q : wb_data_q;
  assign HostRdData  = regs_q[HostRdAddr];
  assign bus.Command = cmd_q;
  assign bus.RegFile = regs_q;

`ifdef RV_REGFILE_WB_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (WbDone) retire_d = retire_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) retire_q <= '0;
    else     retire_q <= retire_d;
  end

  assign RetireCnt = retire_q;
`else
  assign RetireCnt = '0;
`endif

endmodule

// File: tb/tb_rv_regfile_wb.sv
// ----------------------------------------------------------------------------
// tb_rv_regfile_wb
// Bench for rv_regfile_wb. A behavioural R-type ALU sits between Command /
// RegFile and AluResult. Every accepted command pushes its expected outcome
// into a queue; an independent monitor pops and compares whenever the DUT
// raises WbDone or Illegal. A register-array model tracks architectural state.
// ----------------------------------------------------------------------------
module tb_rv_regfile_wb;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        HostWrEn;
  logic [4:0]  HostWrAddr;
  logic [31:0] HostWrData;
  logic [4:0]  HostRdAddr;
  logic [31:0] HostRdData;
  logic        WbDone;
  logic [4:0]  WbRd;
  logic [31:0] WbData;
  logic        Illegal;
  logic [31:0] RetireCnt;

  rv_regfile_wb_if bus ();

  rv_regfile_wb dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .bus        (bus),
    .HostWrEn   (HostWrEn),
    .HostWrAddr (HostWrAddr),
    .HostWrData (HostWrData),
    .HostRdAddr (HostRdAddr),
    .HostRdData (HostRdData),
    .WbDone     (WbDone),
    .WbRd       (WbRd),
    .WbData     (WbData),
    .Illegal    (Illegal),
    .RetireCnt  (RetireCnt)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // R-type arithmetic on two operands.
  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    alu_op = alt ? a - b : a + b;
      3'd1:    alu_op = a << b[4:0];
      3'd2:    alu_op = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    alu_op = (a < b) ? 32'd1 : 32'd0;
      3'd4:    alu_op = a ^ b;
      3'd5:    alu_op = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  always_comb
    bus.AluResult = alu_op(bus.Command[14:12], bus.Command[30],
                           bus.RegFile[bus.Command[19:15]],
                           bus.RegFile[bus.Command[24:20]]);

  function automatic bit model_legal(input logic [31:0] c);
    if (c[6:0] != 7'h33) return 1'b0;
    if (c[31:25] == 7'h00) return 1'b1;
    if (c[31:25] == 7'h20 && (c[14:12] == 3'd0 || c[14:12] == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    bit          illegal;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] instr;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] m [32];
  logic [31:0] exp_retire;
  logic [4:0]  last_rd;
  logic [31:0] last_data;
  int          last_wait;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = '0;
    exp_retire = '0;
    last_rd    = '0;
    last_data  = '0;
  endtask

  // Monitor: every output pulse must match the oldest outstanding command.
  always @(negedge Clk) begin
    if (WbDone || Illegal) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", {30'd0, WbDone, Illegal}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("illegal_flag", {31'd0, Illegal}, {31'd0, mon_e.illegal});
        check("done_flag", {31'd0, WbDone}, {31'd0, !mon_e.illegal});
        check("out_cycle", cyc, mon_e.cyc);
        check("command_stable", bus.Command, mon_e.instr);
        if (!mon_e.illegal) begin
          check("wb_rd", {27'd0, WbRd}, {27'd0, mon_e.rd});
          check("wb_data", WbData, mon_e.data);
        end
      end
    end
  end

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      HostRdAddr = i[4:0];
      #1;
      check({tag, "_regfile"}, bus.RegFile[i], m[i]);
      check({tag, "_hostrd"}, HostRdData, m[i]);
    end
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; HostWrEn = 1'b0; bus.InstrValid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("ready_during_rst", {31'd0, bus.InstrReady}, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_clear();
    @(negedge Clk);
    check("ready_after_rst", {31'd0, bus.InstrReady}, 32'd1);
    check("rst_command", bus.Command, 32'd0);
    check("rst_wbrd", {27'd0, WbRd}, 32'd0);
    check("rst_wbdata", WbData, 32'd0);
    check("rst_retire", RetireCnt, 32'd0);
    @(posedge Clk); #1;
    check_all_regs("rst");
  endtask

  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    HostWrEn = 1'b1; HostWrAddr = a; HostWrData = d;
    @(negedge Clk);
    check("ready_low_on_hostwr", {31'd0, bus.InstrReady}, 32'd0);
    @(posedge Clk); #1;
    HostWrEn = 1'b0;
    if (a != 5'd0) m[a] = d;
  endtask

  task automatic issue(input logic [31:0] instr);
    exp_t        e;
    int          waited;
    logic [4:0]  rd;
    waited = 0;
    rd     = instr[11:7];
    bus.InstrValid  = 1'b1;
    bus.Instruction = instr;
    @(negedge Clk);
    while (!bus.InstrReady && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    last_wait = waited;
    if (!bus.InstrReady) begin
      check("handshake_timeout", 32'd0, 32'd1);
      bus.InstrValid = 1'b0;
      @(posedge Clk); #1;
      return;
    end
    e.instr   = instr;
    e.cyc     = cyc + 2;
    e.illegal = !model_legal(instr);
    e.rd      = rd;
    e.data    = alu_op(instr[14:12], instr[30], m[instr[19:15]], m[instr[24:20]]);
    sbq.push_back(e);
    @(posedge Clk); #1;          // EXEC
    bus.InstrValid = 1'b0;
    HostRdAddr     = rd;
    @(posedge Clk); #1;          // WB: write not visible yet
    check("no_bypass", HostRdData, m[rd]);
    if (!e.illegal) begin
      if (rd != 5'd0) m[rd] = e.data;
      last_rd   = rd;
      last_data = e.data;
`ifdef RV_REGFILE_WB_RETIRE_CNT_EN
      exp_retire = exp_retire + 32'd1;
`endif
    end
    @(posedge Clk); #1;          // back in IDLE
    check("host_rd_after", HostRdData, m[rd]);
    check("wbrd_hold", {27'd0, WbRd}, {27'd0, last_rd});
    check("wbdata_hold", WbData, last_data);
    check("retire_cnt", RetireCnt, exp_retire);
  endtask

  task automatic abort_at(input int stage);
    bus.InstrValid  = 1'b1;
    bus.Instruction = 32'h002081B3;
    @(negedge Clk);
    check("abort_hs_ready", {31'd0, bus.InstrReady}, 32'd1);
    @(posedge Clk); #1;
    bus.InstrValid = 1'b0;
    if (stage == 2) begin
      @(posedge Clk); #1;
    end
    Rst = 1'b1;
    @(negedge Clk);
    check("abort_no_done", {31'd0, WbDone}, 32'd0);
    check("abort_no_illegal", {31'd0, Illegal}, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_clear();
    @(negedge Clk);
    check("abort_after_done", {31'd0, WbDone}, 32'd0);
    check("abort_retire", RetireCnt, 32'd0);
    @(posedge Clk); #1;
    check_all_regs("abort");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] w;
    f3 = 3'($urandom_range(0, 7));
    f7 = 7'h00;
    if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
    case ($urandom_range(0, 9))
      0:       w = $urandom;
      1:       begin
                 f7 = ($urandom_range(0, 1) == 1) ? 7'h01 : 7'h20;
                 if (f7 == 7'h20) f3 = 3'd1;
                 w = {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33};
               end
      default: w = {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33};
    endcase
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; HostWrEn = 1'b0; HostWrAddr = '0; HostWrData = '0;
    HostRdAddr = '0; bus.InstrValid = 1'b0; bus.Instruction = '0;
    model_clear();
    do_reset();

    // add x3,x1,x2 with 5+3
    host_write(5'd1, 32'd5);
    host_write(5'd2, 32'd3);
    issue(32'h002081B3);
    HostRdAddr = 5'd3; #1;
    check("add_x3", HostRdData, 32'd8);
    @(posedge Clk); #1;

    // sub x3,x1,x2 with 3-5
    host_write(5'd1, 32'd3);
    host_write(5'd2, 32'd5);
    issue(32'h402081B3);
    HostRdAddr = 5'd3; #1;
    check("sub_x3", HostRdData, 32'hFFFFFFFE);
    @(posedge Clk); #1;

    // rd = x0 commits but never writes
    issue(32'h00208033);
    check("x0_after_cmd", bus.RegFile[0], 32'd0);
    host_write(5'd0, 32'h0000FFFF);
    HostRdAddr = 5'd0; #1;
    check("x0_host_rd", HostRdData, 32'd0);
    check("x0_regfile", bus.RegFile[0], 32'd0);
    @(posedge Clk); #1;

    // addi is not R-type
    issue(32'h00508193);
    HostRdAddr = 5'd3; #1;
    check("x3_after_illegal", HostRdData, 32'hFFFFFFFE);
    @(posedge Clk); #1;

    // host write and command together: write wins, command next cycle
    HostWrEn = 1'b1; HostWrAddr = 5'd4; HostWrData = 32'h100;
    bus.InstrValid = 1'b1; bus.Instruction = 32'h001202B3;
    @(negedge Clk);
    check("ready_low_both", {31'd0, bus.InstrReady}, 32'd0);
    @(posedge Clk); #1;
    HostWrEn = 1'b0;
    m[4] = 32'h100;
    issue(32'h001202B3);
    check("accept_next_cycle", last_wait, 32'd0);
    HostRdAddr = 5'd5; #1;
    check("x5_sum", HostRdData, 32'h103);
    @(posedge Clk); #1;

    // reset during EXEC and during WB
    host_write(5'd1, 32'd7);
    abort_at(1);
    host_write(5'd2, 32'd9);
    abort_at(2);

    // four legal commits after reset
    host_write(5'd1, 32'd11);
    for (int i = 0; i < 4; i++) issue(32'h001080B3);
`ifdef RV_REGFILE_WB_RETIRE_CNT_EN
    check("retire_four", RetireCnt, 32'd4);
`else
    check("retire_off", RetireCnt, 32'd0);
`endif

    // randomized mix of host writes and commands
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 3) host_write(5'($urandom), $urandom);
      else                          issue(rand_instr());
    end

    check_all_regs("final");
    repeat (3) @(posedge Clk);
    #1;
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rv_regfile_wb.md
RV_REGFILE_WB -- requirements
Module: rv_regfile_wb

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: Clk, Rst.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 InstrValid  input  1  Instruction holds a command to execute.
REQ-005 Instruction  input  32  RV32 command word.
REQ-006 InstrReady  output  1  command accepted on the edge where InstrValid&InstrReady.
REQ-007 Command  output  32  latched command driven to the ALU command input.
REQ-008 RegFile  output  32x32  unpacked register array driven to the ALU reg_file input.
REQ-009 AluResult  input  32  ALU result for Command.
REQ-010 HostWrEn, HostWrAddr[4:0], HostWrData[31:0]  input  host preload port.
REQ-011 HostRdAddr  input  5; HostRdData  output  32  combinational host read.
REQ-012 WbDone  output  1  one-cycle pulse on commit; WbRd[4:0] and WbData[31:0] are valid with it.
REQ-013 Illegal  output  1  one-cycle pulse when the latched command is not a legal R-type.
REQ-014 RetireCnt  output  32  committed-instruction count (see Configuration).

Function
REQ-015 SHALL implement FSM IDLE->EXEC->WB->IDLE; peak throughput is one command per 3 cycles.
REQ-016 IDLE: InstrReady = !HostWrEn; on handshake, latch Instruction into Command and go to EXEC.
REQ-017 IDLE with HostWrEn=1: write HostWrData to reg[HostWrAddr] (ignored for addr 0); command not accepted that cycle.
REQ-018 HostWrEn outside IDLE SHALL be ignored.
REQ-019 EXEC: capture AluResult into an internal result register; evaluate legality; go to WB.
REQ-020 Legal means all of the following:
  - opcode[6:0]=0110011;
  - funct7 is 0000000, or funct7 is 0100000 with funct3 000 or 101.
REQ-021 WB, legal command with rd!=0: reg[rd] <= result; WbDone=1, WbRd=rd, WbData=result.
REQ-022 WB, legal command with rd=0: no write; WbDone=1, WbRd=0, WbData=result.
REQ-023 WB, illegal command: no write; Illegal=1, WbDone=0.
REQ-024 reg[0] SHALL read 0 at all times on RegFile and HostRdData.
REQ-025 Command SHALL remain stable from EXEC through WB and change only on a new handshake.
REQ-026 HostRdData SHALL reflect writes from the following cycle; no same-cycle bypass.
REQ-027 WbRd and WbData SHALL hold their last values when WbDone=0.

Reset
REQ-028 Rst=1 on any edge SHALL put the FSM in IDLE and clear all 32 registers, Command, the result register, WbRd, WbData and RetireCnt to 0.
REQ-029 Rst=1 in EXEC or WB SHALL abort the command with no register write, no WbDone and no Illegal.
REQ-030 InstrReady SHALL be 0 while Rst=1 and 1 on the first cycle after release if HostWrEn=0.

Configuration
REQ-031 Macro RV_REGFILE_WB_RETIRE_CNT_EN:
  - defined: RetireCnt increments by 1 on every WbDone, wrapping 0xFFFFFFFF->0;
  - undefined: RetireCnt is constant 0 and the counter is not synthesized.

Verification
Bench instantiates the team's R-type ALU between Command/RegFile and AluResult.
REQ-032 Host write x1=5, x2=3; issue 0x002081B3 (add x3,x1,x2) -> WbDone 2 cycles after handshake, WbRd=3, WbData=8; HostRdData(3)=8 next cycle.
REQ-033 Issue 0x402081B3 (sub) with x1=3, x2=5 -> x3=0xFFFFFFFE.
REQ-034 Issue 0x00208033 (rd=x0) -> WbDone=1, WbRd=0; x0 still reads 0. Host write x0=0xFFFF -> x0 reads 0.
REQ-035 Issue 0x00508193 (addi) -> Illegal pulse, no WbDone, x3 unchanged, RetireCnt unchanged.
REQ-036 HostWrEn and InstrValid both 1 in IDLE -> host write completes, InstrReady=0; command accepted the next cycle.
REQ-037 Rst asserted in EXEC -> no commit, all registers 0, RetireCnt=0. With macro defined, 4 legal commands -> RetireCnt=4.
